id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall detection and operand forwarding
module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [31:0]            id_pc,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [31:0]            id_rdata1,
  input  logic [31:0]            id_rdata2,
  input  logic [31:0]            id_imm,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic [3:0]             id_alu_op,
  input  logic                   flush,
  input  logic                   mem_reg_write,
  input  logic [4:0]             mem_wr,
  input  logic [31:0]            mem_result,
  input  logic                   wb_reg_write,
  input  logic [4:0]             wb_wr,
  input  logic [31:0]            wb_data,
  output logic                   ex_valid,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_op1,
  output logic [31:0]            ex_op2,
  output logic [31:0]            ex_imm,
  output logic [4:0]             ex_rd,
  output logic [4:0]             ex_rt,
  output logic [3:0]             ex_alu_op,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   valid_q, reg_write_q, mem_read_q, mem_write_q;
  logic                   valid_d, reg_write_d, mem_read_d, mem_write_d;
  logic [31:0]            pc_q, op1_q, op2_q, imm_q;
  logic [31:0]            pc_d, op1_d, op2_d, imm_d;
  logic [4:0]             rd_q, rt_q, rd_d, rt_d;
  logic [3:0]             alu_op_q, alu_op_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   bubble;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_data);
    if (src == 5'd0)                          return rf_data;
    else if (mem_reg_write && mem_wr == src)  return mem_result;
    else if (wb_reg_write && wb_wr == src)    return wb_data;
    else                                      return rf_data;
  endfunction

  // A load in EX whose destination feeds the decode slot must wait one cycle.
  assign stall = id_valid & valid_q & mem_read_q & (rd_q != 5'd0) &
                 ((rd_q == id_rs) | (rd_q == id_rt)) & ~flush;
  assign bubble = flush | stall;

  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    pc_d        = '0;
    op1_d       = '0;
    op2_d       = '0;
    imm_d       = '0;
    rd_d        = '0;
    rt_d        = '0;
    alu_op_d    = '0;
    if (!bubble) begin
      valid_d     = id_valid;
      reg_write_d = id_valid & id_reg_write;
      mem_read_d  = id_valid & id_mem_read;
      mem_write_d = id_valid & id_mem_write;
      pc_d        = id_pc;
      op1_d       = fwd(id_rs, id_rdata1);
      op2_d       = fwd(id_rt, id_rdata2);
      imm_d       = id_imm;
      rd_d        = id_rd;
      rt_d        = id_rt;
      alu_op_d    = id_alu_op;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rt_q        <= '0;
      alu_op_q    <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      pc_q        <= pc_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      rt_q        <= rt_d;
      alu_op_q    <= alu_op_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_pc        = pc_q;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_imm       = imm_q;
  assign ex_rd        = rd_q;
  assign ex_rt        = rt_q;
  assign ex_alu_op    = alu_op_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, flush;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm, mem_result, wb_data;
  logic [4:0]  id_rs, id_rt, id_rd, mem_wr, wb_wr;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd, ex_rt;
  logic [3:0]  ex_alu_op;
  logic [15:0] stall_cnt;

  logic        s_valid, s_reg_write, s_mem_read, s_mem_write, s_stall;
  logic [31:0] s_pc, s_op1, s_op2, s_imm;
  logic [4:0]  s_rd, s_rt;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .flush(flush), .mem_reg_write(mem_reg_write), .mem_wr(mem_wr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_wr(wb_wr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rt(ex_rt), .ex_alu_op(ex_alu_op),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.STALL_CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .flush(flush), .mem_reg_write(mem_reg_write), .mem_wr(mem_wr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_wr(wb_wr), .wb_data(wb_data),
    .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_pc(s_pc), .ex_op1(s_op1), .ex_op2(s_op2),
    .ex_imm(s_imm), .ex_rd(s_rd), .ex_rt(s_rt), .ex_alu_op(s_alu_op),
    .stall(s_stall), .stall_cnt(s_stall_cnt)
  );

  // Expected contents of the execute slot, as an instruction record.
  typedef struct {
    bit        valid, rw, mr, mw;
    bit [31:0] pc, op1, op2, imm;
    bit [4:0]  rd, rt;
    bit [3:0]  alu;
  } slot_t;

  slot_t m;
  int    m_stalls;
  int    checks = 0;
  int    errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] source_value(input bit [4:0] src, input bit [31:0] rf);
    if (src == 0) return rf;
    if (mem_reg_write && mem_wr == src) return mem_result;
    if (wb_reg_write && wb_wr == src) return wb_data;
    return rf;
  endfunction

  function automatic bit model_stall();
    return id_valid && m.valid && m.mr && m.rd != 0 &&
           (m.rd == id_rs || m.rd == id_rt) && !flush;
  endfunction

  // Inputs are already applied at the falling edge; check stall, advance the model, check outputs.
  task automatic step();
    bit    exp_stall;
    slot_t nxt;
    #1;
    exp_stall = model_stall();
    check_eq("stall", {63'd0, stall}, {63'd0, exp_stall});
    check_eq("stall_small", {63'd0, s_stall}, {63'd0, exp_stall});
    nxt = '{default: 0};
    if (!rst_n) begin
      m_stalls = 0;
    end else if (flush || exp_stall) begin
      if (exp_stall) m_stalls++;
    end else begin
      nxt.valid = id_valid;
      nxt.rw    = id_valid && id_reg_write;
      nxt.mr    = id_valid && id_mem_read;
      nxt.mw    = id_valid && id_mem_write;
      nxt.pc    = id_pc;
      nxt.op1   = source_value(id_rs, id_rdata1);
      nxt.op2   = source_value(id_rt, id_rdata2);
      nxt.imm   = id_imm;
      nxt.rd    = id_rd;
      nxt.rt    = id_rt;
      nxt.alu   = id_alu_op;
    end
    m = nxt;
    @(posedge clk);
    #1;
    check_eq("ctrl", {60'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
             {60'd0, m.valid, m.rw, m.mr, m.mw});
    check_eq("pc_imm", {ex_pc, ex_imm}, {m.pc, m.imm});
    check_eq("ops", {ex_op1, ex_op2}, {m.op1, m.op2});
    check_eq("fields", {50'd0, ex_rd, ex_rt, ex_alu_op}, {50'd0, m.rd, m.rt, m.alu});
    check_eq("stall_cnt", {48'd0, stall_cnt}, 64'(m_stalls > 65535 ? 65535 : m_stalls));
    check_eq("stall_cnt_small", {62'd0, s_stall_cnt}, 64'(m_stalls > 3 ? 3 : m_stalls));
    check_eq("small_ctrl", {60'd0, s_valid, s_reg_write, s_mem_read, s_mem_write},
             {60'd0, m.valid, m.rw, m.mr, m.mw});
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    id_valid      = ($urandom_range(0, 9) != 0);
    id_pc         = $urandom;
    id_rs         = 5'($urandom_range(0, 7));
    id_rt         = 5'($urandom_range(0, 7));
    id_rd         = 5'($urandom_range(0, 7));
    id_rdata1     = $urandom;
    id_rdata2     = $urandom;
    id_imm        = $urandom;
    id_reg_write  = 1'($urandom);
    id_mem_read   = ($urandom_range(0, 2) == 0);
    id_mem_write  = 1'($urandom);
    id_alu_op     = 4'($urandom);
    flush         = ($urandom_range(0, 7) == 0);
    mem_reg_write = 1'($urandom);
    mem_wr        = 5'($urandom_range(0, 7));
    mem_result    = $urandom;
    wb_reg_write  = 1'($urandom);
    wb_wr         = 5'($urandom_range(0, 7));
    wb_data       = $urandom;
  endtask

  task automatic quiet_inputs();
    randomize_inputs();
    id_valid = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      step();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m = '{default: 0};
    m_stalls = 0;
    rst_n = 1'b0;
    randomize_inputs();
    @(negedge clk);
    do_reset();
    check_eq("reset_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("reset_op1", {32'd0, ex_op1}, 64'd0);
    check_eq("reset_cnt", {48'd0, stall_cnt}, 64'd0);

    // Pass-through with no forwarding sources active.
    quiet_inputs();
    id_rs = 5'd3; id_rdata1 = 32'h11; id_rd = 5'd5; id_reg_write = 1'b1;
    step();
    check_eq("pass_valid", {63'd0, ex_valid}, 64'd1);
    check_eq("pass_op1", {32'd0, ex_op1}, 64'h11);
    check_eq("pass_rd", {59'd0, ex_rd}, 64'd5);
    check_eq("pass_rw", {63'd0, ex_reg_write}, 64'd1);

    // EX/MEM beats MEM/WB; register 0 is never forwarded.
    quiet_inputs();
    id_rs = 5'd7; mem_reg_write = 1'b1; mem_wr = 5'd7; mem_result = 32'hAAAA;
    wb_reg_write = 1'b1; wb_wr = 5'd7; wb_data = 32'hBBBB;
    step();
    check_eq("fwd_prio", {32'd0, ex_op1}, 64'hAAAA);
    id_rs = 5'd0; mem_wr = 5'd0; wb_wr = 5'd0; id_rdata1 = 32'h1234_5678;
    step();
    check_eq("fwd_r0", {32'd0, ex_op1}, 64'h1234_5678);

    // Load-use: one stall, then the consumer issues with MEM/WB data.
    do_reset();
    quiet_inputs();
    id_mem_read = 1'b1; id_rd = 5'd4; id_rs = 5'd1; id_rt = 5'd2;
    step();
    quiet_inputs();
    id_rs = 5'd1; id_rt = 5'd4;
    #1;
    check_eq("lu_stall", {63'd0, stall}, 64'd1);
    step();
    check_eq("lu_bubble", {63'd0, ex_valid}, 64'd0);
    check_eq("lu_cnt", {48'd0, stall_cnt}, 64'd1);
    wb_reg_write = 1'b1; wb_wr = 5'd4; wb_data = 32'hCAFE_0004;
    #1;
    check_eq("lu_release", {63'd0, stall}, 64'd0);
    step();
    check_eq("lu_op2", {32'd0, ex_op2}, 64'hCAFE_0004);

    // Flush beats a load-use hazard and leaves the counter alone.
    quiet_inputs();
    id_mem_read = 1'b1; id_rd = 5'd6;
    step();
    quiet_inputs();
    id_rt = 5'd6; flush = 1'b1;
    step();
    check_eq("flush_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("flush_cnt", {48'd0, stall_cnt}, 64'd1);

    // Narrow counter saturates at 3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      quiet_inputs();
      id_mem_read = 1'b1; id_rd = 5'd4;
      step();
      quiet_inputs();
      id_rt = 5'd4;
      step();
      check_eq("sat_cnt", {62'd0, s_stall_cnt}, 64'(i < 3 ? i + 1 : 3));
    end

    // Random traffic, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
